// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one ROM/RAM port between fetch and data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter logic [31:0] ROM_BASE     = 32'h00400000,
  parameter logic [31:0] RAM_BASE     = 32'h10100000
) (
  input  logic                  clk,
  input  logic                  reset,
  // fetch port
  input  logic                  If_Req_i,
  input  logic [DATA_WIDTH-1:0] If_Addr_i,
  output logic                  If_Ack_o,
  output logic [DATA_WIDTH-1:0] If_Data_o,
  output logic                  If_Err_o,
  // data port
  input  logic                  Dm_Req_i,
  input  logic                  Dm_We_i,
  input  logic [DATA_WIDTH-1:0] Dm_Addr_i,
  input  logic [DATA_WIDTH-1:0] Dm_Wdata_i,
  output logic                  Dm_Ack_o,
  output logic [DATA_WIDTH-1:0] Dm_Data_o,
  output logic                  Dm_Err_o,
  // memory side
  output logic                  Mem_Write_Enable_o,
  output logic [DATA_WIDTH-1:0] Mem_Address_o,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ROM_LO    = DATA_WIDTH'(ROM_BASE);
  localparam logic [DATA_WIDTH-1:0] RAM_LO    = DATA_WIDTH'(RAM_BASE);
  localparam logic [DATA_WIDTH-1:0] WIN_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;   // 0 = fetch, 1 = data
  logic                    grant_dm_q, grant_dm_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    if_ack_q, if_ack_d;
  logic                    if_err_q, if_err_d;
  logic [DATA_WIDTH-1:0]   if_data_q, if_data_d;
  logic                    dm_ack_q, dm_ack_d;
  logic                    dm_err_q, dm_err_d;
  logic [DATA_WIDTH-1:0]   dm_data_q, dm_data_d;

  logic                    sel_dm;
  logic [DATA_WIDTH-1:0]   sel_addr;
  logic                    sel_we;
  logic                    in_rom;
  logic                    in_ram;
  logic                    req_fault;

  // On a tie the port that was not served last wins.
  assign sel_dm   = Dm_Req_i && (!If_Req_i || !last_grant_q);
  assign sel_addr = sel_dm ? Dm_Addr_i : If_Addr_i;
  assign sel_we   = sel_dm && Dm_We_i;

  // Offset compare avoids overflow when a window ends at the top of the space.
  assign in_rom = (sel_addr >= ROM_LO) && ((sel_addr - ROM_LO) < WIN_BYTES);
  assign in_ram = (sel_addr >= RAM_LO) && ((sel_addr - RAM_LO) < WIN_BYTES);

  always_comb begin
    req_fault = (sel_addr[1:0] != 2'b00);
    if (!sel_dm) begin
      req_fault = req_fault || !in_rom;
    end else if (sel_we) begin
      req_fault = req_fault || !in_ram;
    end else begin
      req_fault = req_fault || !(in_rom || in_ram);
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_dm_d   = grant_dm_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    if_ack_d     = 1'b0;
    if_err_d     = if_err_q;
    if_data_d    = if_data_q;
    dm_ack_d     = 1'b0;
    dm_err_d     = dm_err_q;
    dm_data_d    = dm_data_q;

    case (state_q)
      IDLE: begin
        if (If_Req_i || Dm_Req_i) begin
          grant_dm_d   = sel_dm;
          last_grant_d = sel_dm;
          addr_d       = sel_addr;
          we_d         = sel_we;
          wdata_d      = sel_dm ? Dm_Wdata_i : '0;
          if (req_fault) begin
            // Faulted requests skip the memory entirely and answer next cycle.
            state_d = RESP;
            if (sel_dm) begin
              dm_ack_d  = 1'b1;
              dm_err_d  = 1'b1;
              dm_data_d = '0;
            end else begin
              if_ack_d  = 1'b1;
              if_err_d  = 1'b1;
              if_data_d = '0;
            end
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        state_d = WAIT;
      end

      WAIT: begin
        state_d = RESP;
        if (grant_dm_q) begin
          dm_ack_d  = 1'b1;
          dm_err_d  = 1'b0;
          dm_data_d = we_q ? '0 : Mem_Read_Data_i;
        end else begin
          if_ack_d  = 1'b1;
          if_err_d  = 1'b0;
          if_data_d = Mem_Read_Data_i;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      grant_dm_q   <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      if_data_q    <= '0;
      dm_ack_q     <= 1'b0;
      dm_err_q     <= 1'b0;
      dm_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_dm_q   <= grant_dm_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      if_ack_q     <= if_ack_d;
      if_err_q     <= if_err_d;
      if_data_q    <= if_data_d;
      dm_ack_q     <= dm_ack_d;
      dm_err_q     <= dm_err_d;
      dm_data_q    <= dm_data_d;
    end
  end

  // Memory strobes decode straight from the state so reset kills them at once.
  assign Mem_Write_Enable_o = (state_q == ISSUE) && we_q;
  assign Mem_Address_o      = ((state_q == ISSUE) || (state_q == WAIT)) ? addr_q : '0;
  assign Mem_Write_Data_o   = (((state_q == ISSUE) || (state_q == WAIT)) && we_q) ? wdata_q : '0;

  assign If_Ack_o  = if_ack_q;
  assign If_Err_o  = if_err_q;
  assign If_Data_o = if_data_q;
  assign Dm_Ack_o  = dm_ack_q;
  assign Dm_Err_o  = dm_err_q;
  assign Dm_Data_o = dm_data_q;

endmodule
`default_nettype wire
